// File: rtl/output_argmax.sv
// Scans the output-unit RAM through its registered-read port and reports the
// index and value of the largest unsigned activation (lowest index on ties).
module output_argmax #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_UNITS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] digit,
  output logic [DATA_WIDTH-1:0] max_val
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_UNITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_req_done;
  logic                    r_vld;
  logic [ADDR_WIDTH-1:0]   r_cmp_idx;
  logic [DATA_WIDTH-1:0]   r_best_val;
  logic [ADDR_WIDTH-1:0]   r_best_idx;
  logic                    r_busy;
  logic                    r_done;
  logic [ADDR_WIDTH-1:0]   r_digit;
  logic [DATA_WIDTH-1:0]   r_max_val;

  logic                    w_take;
  logic [DATA_WIDTH-1:0]   w_next_val;
  logic [ADDR_WIDTH-1:0]   w_next_idx;
  logic                    w_last;

  always_comb begin
    w_take     = (r_cmp_idx == '0) || (ram_q > r_best_val);
    w_next_val = w_take ? ram_q     : r_best_val;
    w_next_idx = w_take ? r_cmp_idx : r_best_idx;
    w_last     = r_vld && (r_cmp_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req_done <= 1'b0;
      r_vld      <= 1'b0;
      r_cmp_idx  <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_digit    <= '0;
      r_max_val  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= SCAN;
            r_cnt      <= '0;
            r_req_done <= 1'b0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (r_cnt != LAST_IDX) r_cnt <= r_cnt + 1'b1;
          else                   r_req_done <= 1'b1;
          // ram_q carries entry r_cnt one cycle after it was addressed
          r_vld     <= !r_req_done;
          r_cmp_idx <= r_cnt;
          if (r_vld) begin
            r_best_val <= w_next_val;
            r_best_idx <= w_next_idx;
          end
          if (w_last) begin
            r_digit   <= w_next_idx;
            r_max_val <= w_next_val;
            r_done    <= 1'b1;
            r_vld     <= 1'b0;
            // A start seen on the completion edge chains straight into the
            // next scan so back-to-back scans take NUM_UNITS+1 cycles each.
            if (start) begin
              r_cnt      <= '0;
              r_req_done <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_addr = (r_state == SCAN) ? r_cnt : '0;
  assign busy     = r_busy;
  assign done     = r_done;
  assign digit    = r_digit;
  assign max_val  = r_max_val;

endmodule

// File: tb/tb_output_argmax.sv
// Directed self-checking bench for output_argmax with a behavioural
// registered-read RAM of ten entries.
module tb_output_argmax;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ram_addr;
  logic [7:0] ram_q = '0;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic [7:0] max_val;

  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  output_argmax #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .NUM_UNITS (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ram_addr(ram_addr),
    .ram_q   (ram_q),
    .busy    (busy),
    .done    (done),
    .digit   (digit),
    .max_val (max_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3; mem[4] = v4;
    mem[5] = v5; mem[6] = v6; mem[7] = v7; mem[8] = v8; mem[9] = v9;
  endtask

  // Drives one start pulse and reports what the DUT did; callers compare.
  task automatic run_scan(output int lat, output logic [3:0] dg,
                          output logic [7:0] mv, output logic wide);
    lat = -1;
    dg = '0;
    mv = '0;
    wide = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (done) begin
        lat = j;
        dg = digit;
        mv = max_val;
        step();
        wide = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++;
      if ({busy, done, digit, max_val, ram_addr} !== 18'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d busy=%b done=%b digit=%0d max=%0d addr=%0d, required all 0",
                 c, busy, done, digit, max_val, ram_addr);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    load(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd5);
    lat = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ram_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL basic_edge0 busy=%b addr=%0d, required busy=1 addr=0", busy, ram_addr);
    end
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j <= 9) begin
        n_cmp++;
        if (ram_addr !== 4'(j)) begin
          n_bad++;
          $display("FAIL basic_addr edge=%0d got %0d, required %0d", j, ram_addr, j);
        end
      end
      if (done) begin
        lat = j;
        break;
      end
    end
    n_cmp++;
    if (lat != 11) begin
      n_bad++;
      $display("FAIL basic_latency got %0d, required 11", lat);
    end
    n_cmp++;
    if (digit !== 4'd8 || max_val !== 8'd90) begin
      n_bad++;
      $display("FAIL basic_result digit=%0d max=%0d, required digit=8 max=90", digit, max_val);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse done=%b busy=%b, required done=0 busy=0", done, busy);
    end
    repeat (3) step();
    n_cmp++;
    if (digit !== 4'd8 || max_val !== 8'd90) begin
      n_bad++;
      $display("FAIL basic_hold digit=%0d max=%0d, required digit=8 max=90", digit, max_val);
    end
  endtask

  task automatic test_ties();
    int lat;
    logic [3:0] dg;
    logic [7:0] mv;
    logic wide;
    load(8'h40, 8'hFF, 8'd3, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_scan(lat, dg, mv, wide);
    n_cmp++;
    if (lat != 11 || dg !== 4'd1 || mv !== 8'hFF || wide !== 1'b0) begin
      n_bad++;
      $display("FAIL ties lat=%0d digit=%0d max=%h wide=%b, required lat=11 digit=1 max=ff wide=0",
               lat, dg, mv, wide);
    end
  endtask

  task automatic test_zeros();
    int lat;
    logic [3:0] dg;
    logic [7:0] mv;
    logic wide;
    load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_scan(lat, dg, mv, wide);
    n_cmp++;
    if (lat != 11 || dg !== 4'd0 || mv !== 8'd0 || wide !== 1'b0) begin
      n_bad++;
      $display("FAIL zeros lat=%0d digit=%0d max=%0d wide=%b, required lat=11 digit=0 max=0 wide=0",
               lat, dg, mv, wide);
    end
  endtask

  task automatic test_last();
    int lat;
    logic [3:0] dg;
    logic [7:0] mv;
    logic wide;
    load(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80);
    run_scan(lat, dg, mv, wide);
    n_cmp++;
    if (lat != 11 || dg !== 4'd9 || mv !== 8'h80 || wide !== 1'b0) begin
      n_bad++;
      $display("FAIL last_entry lat=%0d digit=%0d max=%h wide=%b, required lat=11 digit=9 max=80 wide=0",
               lat, dg, mv, wide);
    end
  endtask

  task automatic test_back_to_back();
    int pos [8];
    int np;
    np = 0;
    load(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd5);
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (c == 29) start = 1'b0;
      if (done && np < 8) begin
        pos[np] = c;
        np++;
      end
    end
    n_cmp++;
    if (np != 3) begin
      n_bad++;
      $display("FAIL b2b_count got %0d pulses, required 3", np);
    end else begin
      n_cmp++;
      if (pos[0] != 11 || pos[1] != 22 || pos[2] != 33) begin
        n_bad++;
        $display("FAIL b2b_spacing pulses at %0d,%0d,%0d, required 11,22,33", pos[0], pos[1], pos[2]);
      end
    end
    n_cmp++;
    if (digit !== 4'd8 || max_val !== 8'd90 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_result digit=%0d max=%0d busy=%b, required digit=8 max=90 busy=0",
               digit, max_val, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    logic [3:0] dg;
    logic [7:0] mv;
    logic wide;
    int spurious;
    load(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, digit, max_val, ram_addr} !== 18'd0) begin
      n_bad++;
      $display("FAIL rst_mid busy=%b done=%b digit=%0d max=%0d addr=%0d, required all 0",
               busy, done, digit, max_val, ram_addr);
    end
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL rst_no_done got %0d active cycles, required 0", spurious);
    end
    load(8'd1, 8'd2, 8'd3, 8'd200, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    run_scan(lat, dg, mv, wide);
    n_cmp++;
    if (lat != 11 || dg !== 4'd3 || mv !== 8'd200 || wide !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rescan lat=%0d digit=%0d max=%0d wide=%b, required lat=11 digit=3 max=200 wide=0",
               lat, dg, mv, wide);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ties();
    test_zeros();
    test_last();
    test_back_to_back();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
